// File: rtl/mult_accumulator.sv
// Product accumulator: sums LEN incoming product words into an ACC_SZ-bit
// result with a sticky wrap flag, then holds the result until the consumer
// takes it.
//
// Ports:
//   clk        - clock, rising edge
//   rst_l      - asynchronous active-low reset
//   clr        - synchronous abort of the current accumulation / pending result
//   in_valid   - in_prod carries a valid product
//   in_prod    - product word, BIT_SZ bits, zero-extended into the accumulator
//   in_ready   - block accepts a product this cycle (state decode, combinational)
//   out_valid  - out_sum / out_ovf hold a completed result
//   out_ready  - consumer accepts the result
//   out_sum    - completed sum of LEN products, ACC_SZ bits
//   out_ovf    - accumulation for this result wrapped
module mult_accumulator #(
    parameter int unsigned BIT_SZ = 4,
    parameter int unsigned ACC_SZ = 8,
    parameter int unsigned LEN    = 4
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [BIT_SZ-1:0] in_prod,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_SZ-1:0] out_sum,
    output logic              out_ovf
);

    localparam int unsigned CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int unsigned SUM_W = ACC_SZ + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [ACC_SZ-1:0] acc, acc_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              ovf, ovf_nxt;
    logic              out_valid_nxt;
    logic [ACC_SZ-1:0] out_sum_nxt;
    logic              out_ovf_nxt;
    logic [SUM_W-1:0]  sum_ext;

    // Extra top bit of the sum is the carry out of the accumulator
    assign sum_ext  = {1'b0, acc} + SUM_W'(in_prod);
    assign in_ready = (state == ACCUM);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            ovf       <= ovf_nxt;
            out_valid <= out_valid_nxt;
            out_sum   <= out_sum_nxt;
            out_ovf   <= out_ovf_nxt;
        end
    end

    // Next-state and datapath decode; clr overrides everything
    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        cnt_nxt       = cnt;
        ovf_nxt       = ovf;
        out_valid_nxt = out_valid;
        out_sum_nxt   = out_sum;
        out_ovf_nxt   = out_ovf;

        if (clr) begin
            state_nxt     = ACCUM;
            acc_nxt       = '0;
            cnt_nxt       = '0;
            ovf_nxt       = 1'b0;
            out_valid_nxt = 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        if (cnt == LAST_CNT) begin
                            // Last product: publish result and restart
                            out_sum_nxt   = sum_ext[ACC_SZ-1:0];
                            out_ovf_nxt   = ovf | sum_ext[ACC_SZ];
                            out_valid_nxt = 1'b1;
                            state_nxt     = HOLD;
                            acc_nxt       = '0;
                            cnt_nxt       = '0;
                            ovf_nxt       = 1'b0;
                        end else begin
                            acc_nxt = sum_ext[ACC_SZ-1:0];
                            ovf_nxt = ovf | sum_ext[ACC_SZ];
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_nxt = 1'b0;
                        state_nxt     = ACCUM;
                    end
                end
                default: begin
                    state_nxt = ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_accumulator.sv
// Directed testbench for mult_accumulator: default instance (ACC_SZ=8) and an
// ACC_SZ=5 instance driven by the same stimulus for the wrap check.
module tb_mult_accumulator;

    logic       clk;
    logic       rst_l;
    logic       clr;
    logic       in_valid;
    logic [3:0] in_prod;
    logic       out_ready;

    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_sum;
    logic       out_ovf;

    logic       in_ready5;
    logic       out_valid5;
    logic [4:0] out_sum5;
    logic       out_ovf5;

    int n_checks;
    int n_fail;

    mult_accumulator u_dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_prod   (in_prod),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    mult_accumulator #(.BIT_SZ(4), .ACC_SZ(5), .LEN(4)) u_dut5 (
        .clk       (clk),
        .rst_l     (rst_l),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_prod   (in_prod),
        .in_ready  (in_ready5),
        .out_valid (out_valid5),
        .out_ready (out_ready),
        .out_sum   (out_sum5),
        .out_ovf   (out_ovf5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one product for exactly one edge
    task automatic push(input logic [3:0] p);
        in_valid = 1'b1;
        in_prod  = p;
        step();
        in_valid = 1'b0;
    endtask

    // Let any held result drain with out_ready=1
    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_l = 1'b0; clr = 1'b0; in_valid = 1'b0; in_prod = '0; out_ready = 1'b1;
        #12;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_sum !== 8'd0) begin n_fail++; $display("FAIL reset_out_sum: got %0d want 0", out_sum); end
        n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf: got %b want 0", out_ovf); end
        step();
        rst_l = 1'b1;
        step();
    endtask

    task automatic test_basic_sum();
        out_ready = 1'b1;
        push(4'd3);
        push(4'd5);
        push(4'd7);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
        push(4'd9);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        n_checks++; if (out_sum !== 8'd24) begin n_fail++; $display("FAIL basic_sum: got %0d want 24", out_sum); end
        n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b want 0", out_ovf); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_hold_in_ready: got %b want 0", in_ready); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle: got %b want 0", out_valid); end
        n_checks++; if (out_sum !== 8'd24) begin n_fail++; $display("FAIL basic_sum_retained: got %0d want 24", out_sum); end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        push(4'd1);
        push(4'd2);
        push(4'd3);
        in_valid = 1'b1; in_prod = 4'd4;
        step();
        in_prod = 4'd15;  // held upstream while the result is pending
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
            n_checks++; if (out_sum !== 8'd10) begin n_fail++; $display("FAIL bp_sum[%0d]: got %0d want 10", i, out_sum); end
            step();
        end
        out_ready = 1'b1;
        step();  // handshake edge
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_handshake: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %b want 1", in_ready); end
        step();  // 15 accepted as product 1
        in_valid = 1'b0;
        push(4'd1);
        push(4'd1);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_count_early: got %b want 0", out_valid); end
        push(4'd1);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_second_valid: got %b want 1", out_valid); end
        n_checks++; if (out_sum !== 8'd18) begin n_fail++; $display("FAIL bp_second_sum: got %0d want 18", out_sum); end
        drain();
    endtask

    task automatic test_overflow();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(4'd15);
        n_checks++; if (out_valid5 !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %b want 1", out_valid5); end
        n_checks++; if (out_sum5 !== 5'd28) begin n_fail++; $display("FAIL ovf_sum: got %0d want 28", out_sum5); end
        n_checks++; if (out_ovf5 !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", out_ovf5); end
        n_checks++; if (out_sum !== 8'd60) begin n_fail++; $display("FAIL ovf_wide_sum: got %0d want 60", out_sum); end
        n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_wide_flag: got %b want 0", out_ovf); end
        drain();
        for (int i = 0; i < 4; i++) push(4'd1);
        n_checks++; if (out_sum5 !== 5'd4) begin n_fail++; $display("FAIL ovf_next_sum: got %0d want 4", out_sum5); end
        n_checks++; if (out_ovf5 !== 1'b0) begin n_fail++; $display("FAIL ovf_next_flag: got %b want 0", out_ovf5); end
        drain();
    endtask

    task automatic test_stall();
        out_ready = 1'b1;
        push(4'd2);
        for (int i = 0; i < 3; i++) begin
            in_prod = 4'd9;  // ignored while in_valid=0
            step();
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 0", i, out_valid); end
        end
        push(4'd4);
        push(4'd6);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_early: got %b want 0", out_valid); end
        push(4'd8);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid_end: got %b want 1", out_valid); end
        n_checks++; if (out_sum !== 8'd20) begin n_fail++; $display("FAIL stall_sum: got %0d want 20", out_sum); end
        drain();
    endtask

    task automatic test_clear();
        out_ready = 1'b1;
        push(4'd5);
        push(4'd6);
        clr = 1'b1; in_valid = 1'b1; in_prod = 4'd9;
        step();
        clr = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %b want 0", out_valid); end
        for (int i = 0; i < 3; i++) push(4'd1);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_count: got %b want 0", out_valid); end
        push(4'd1);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clr_result_valid: got %b want 1", out_valid); end
        n_checks++; if (out_sum !== 8'd4) begin n_fail++; $display("FAIL clr_sum: got %0d want 4", out_sum); end
        // clr in HOLD beats a simultaneous handshake
        clr = 1'b1; out_ready = 1'b1;
        step();
        clr = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_hold_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL clr_hold_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(4'd2);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre_valid: got %b want 1", out_valid); end
        #2;  // mid-cycle, no clock edge between here and the checks
        rst_l = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", out_valid); end
        n_checks++; if (out_sum !== 8'd0) begin n_fail++; $display("FAIL ar_sum: got %0d want 0", out_sum); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_in_ready: got %b want 1", in_ready); end
        step();
        rst_l = 1'b1;
        out_ready = 1'b1;
        // Partial accumulation discarded by a reset pulse
        push(4'd7);
        push(4'd7);
        rst_l = 1'b0;
        step();
        rst_l = 1'b1;
        push(4'd1);
        push(4'd2);
        push(4'd3);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_recount: got %b want 0", out_valid); end
        push(4'd4);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_after_valid: got %b want 1", out_valid); end
        n_checks++; if (out_sum !== 8'd10) begin n_fail++; $display("FAIL ar_after_sum: got %0d want 10", out_sum); end
        drain();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic_sum();
        test_back_pressure();
        test_overflow();
        test_stall();
        test_clear();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
